riscv_mem_wb: RTL and testbench
===============================

Name: riscv_mem_wb

Overview:
- Memory-access and write-back back end of the two-phase RISC pipeline.
- Consumes the EX/MEM pipeline register outputs of the execute stage.
- Performs data-memory loads and stores, and holds the MEM/WB pipeline register.
- Owns the architectural register file: a write port driven from WB, plus two read ports for the decode stage with write-through bypass. It also raises the global halt.

Parameters:
- DMEM_DEPTH, 1024, number of 32-bit data-memory words. Word addressed, power of two.
- DMEM_AW, 10, log2(DMEM_DEPTH). Width of the used address field.

Ports:
- clk1  in  1  pipeline clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_mem_valid  in  1  EX/MEM register holds a live instruction.
- ex_mem_type  in  3  class: RR_ALU=0, RM_ALU=1, LOAD=2, STORE=3, BRANCH=4, HALT=5.
- ex_mem_ir  in  32  instruction word.
- ex_mem_aluout  in  32  ALU result or effective address.
- ex_mem_b  in  32  store data (rt value).
- taken_branch  in  1  squash: the instruction in EX/MEM is on the wrong path.
- rd_addr_a  in  5  register read address A (rs).
- rd_addr_b  in  5  register read address B (rt).
- rd_data_a  out  32  combinational read data A.
- rd_data_b  out  32  combinational read data B.
- wb_we  out  1  registered write-back strobe (observability).
- wb_addr  out  5  write-back destination.
- wb_data  out  32  write-back data.
- halted  out  1  sticky halt flag.
- mem_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (async, rst_n=0) clears the following to 0:
  - the MEM/WB registers (valid, type, IR, ALUout, LMD);
  - wb_we, wb_addr, wb_data, halted, mem_err;
  - all 32 register-file entries.
- Data-memory contents are not reset.
- Reset mid-operation discards all in-flight instructions. No store completes on or after the reset assertion.
- MEM stage, each edge while halted=0 and no HALT is blocking (see the HALT rule below):
  - live = ex_mem_valid & ~taken_branch.
  - mem_wb_valid <= live. Type, IR and ALUout are copied unconditionally.
- Address decode:
  - addr = ex_mem_aluout[DMEM_AW-1:0].
  - in_range = (ex_mem_aluout[31:DMEM_AW] == 0).
- LOAD (live):
  - in_range: LMD <= dmem[addr].
  - otherwise: LMD <= 0 and mem_err <= 1.
- STORE (live):
  - in_range: dmem[addr] <= ex_mem_b.
  - otherwise: the write is dropped and mem_err <= 1.
- A squashed or invalid STORE never writes memory.
- WB stage, each edge while halted=0, when mem_wb_valid=1:
  - RR_ALU: destination = IR[15:11], data = ALUout.
  - RM_ALU: destination = IR[20:16], data = ALUout.
  - LOAD: destination = IR[20:16], data = LMD.
  - STORE and BRANCH: no register write.
  - Register write happens only if destination != 0. r0 always reads 0.
  - wb_we/wb_addr/wb_data are registered copies of the write performed on that edge. wb_we=0 when there is no write.
- Latency:
  - instruction sampled at EX/MEM on edge N;
  - enters MEM/WB on edge N+1;
  - register-file write and wb_we=1 on edge N+2 (visible after N+2).
- Read ports: combinational Reg[rd_addr].
  - Bypass: if a WB write to the same nonzero address is pending this cycle, return its data.
  - Address 0 always returns 0.
- HALT:
  - A live HALT passes MEM normally.
  - While MEM/WB holds a valid HALT, the MEM stage is blocked: mem_wb_valid <= 0, and no load or store is performed for the instruction in EX/MEM.
  - On the next edge WB sets halted <= 1.
- After halted=1:
  - MEM, WB, the register file, dmem and mem_err are frozen until reset.
  - The read ports remain functional.
- mem_err is sticky until reset. It never blocks the pipeline.
- Simultaneous events:
  - A WB write and a MEM load to unrelated resources both proceed.
  - taken_branch with a HALT in EX/MEM squashes the HALT, so no halt occurs.

Test Plan:
- ADDI result: EX/MEM RM_ALU, IR rt=5, aluout=0x0000000A -> two edges later wb_we=1, wb_addr=5, wb_data=0xA; rd_addr_a=5 returns 0xA.
- Store-then-load:
  - STORE aluout=0x14, b=0xDEADBEEF;
  - next cycle LOAD aluout=0x14, rt=7;
  - -> r7=0xDEADBEEF, mem_err=0.
- Squash: STORE aluout=0x20, b=0x55 with taken_branch=1 -> dmem[0x20] unchanged; no wb_we for that slot.
- Out-of-range: LOAD aluout=0x00000400 (DMEM_DEPTH=1024) -> r destination=0, mem_err=1 and stays 1; a subsequent in-range STORE still succeeds.
- Halt ordering:
  - sequence ADD (rd=3, 0x11), HALT, STORE (aluout=0x8, b=0x99);
  - -> r3=0x11, halted=1 two edges after HALT is sampled, dmem[0x8] unchanged;
  - further inputs cause no writes.
- Reset mid-flight: assert rst_n=0 while a LOAD to r9 is in MEM/WB -> wb_we=0, r9=0, halted=0 immediately (asynchronously); r0 writes never change rd_data (read 0).

Source files
------------

// File: rtl/riscv_mem_wb.sv
// riscv_mem_wb: memory-access and write-back back end of the two-phase RISC
// pipeline. Holds the MEM/WB register, the data memory, the architectural
// register file (with WB-to-decode bypass) and the sticky halt / error flags.
module riscv_mem_wb #(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        ex_mem_valid,
    input  logic [2:0]  ex_mem_type,
    input  logic [31:0] ex_mem_ir,
    input  logic [31:0] ex_mem_aluout,
    input  logic [31:0] ex_mem_b,
    input  logic        taken_branch,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        halted,
    output logic        mem_err
);

    typedef enum logic [2:0] {
        T_RR_ALU = 3'd0,
        T_RM_ALU = 3'd1,
        T_LOAD   = 3'd2,
        T_STORE  = 3'd3,
        T_BRANCH = 3'd4,
        T_HALT   = 3'd5
    } instr_type_e;

    // MEM/WB pipeline register
    logic        mem_wb_valid_q,  mem_wb_valid_d;
    logic [2:0]  mem_wb_type_q,   mem_wb_type_d;
    logic [31:0] mem_wb_ir_q,     mem_wb_ir_d;
    logic [31:0] mem_wb_aluout_q, mem_wb_aluout_d;
    logic [31:0] mem_wb_lmd_q,    mem_wb_lmd_d;

    // Observability and status flops
    logic        wb_we_q,   wb_we_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        halted_q,  halted_d;
    logic        mem_err_q, mem_err_d;

    // Register file and data memory
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] dmem   [DMEM_DEPTH];

    logic               live;
    logic               mem_block;
    logic [DMEM_AW-1:0] dmem_addr;
    logic               in_range;
    logic               dmem_we;

    logic               wr_en;
    logic [4:0]         wr_dest;
    logic [31:0]        wr_data;

    // Only the register-specifier fields of the IR are consumed here
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ex_mem_ir[31:21], ex_mem_ir[10:0],
                              mem_wb_ir_q[31:21], mem_wb_ir_q[10:0]};

    assign dmem_addr = ex_mem_aluout[DMEM_AW-1:0];
    assign in_range  = ~|ex_mem_aluout[31:DMEM_AW];
    assign live      = ex_mem_valid & ~taken_branch;
    assign mem_block = mem_wb_valid_q && (mem_wb_type_q == T_HALT);

    // MEM stage: next MEM/WB contents, load data, store strobe, error flag
    always_comb begin
        mem_wb_valid_d  = mem_wb_valid_q;
        mem_wb_type_d   = mem_wb_type_q;
        mem_wb_ir_d     = mem_wb_ir_q;
        mem_wb_aluout_d = mem_wb_aluout_q;
        mem_wb_lmd_d    = mem_wb_lmd_q;
        mem_err_d       = mem_err_q;
        dmem_we         = 1'b0;
        if (!halted_q) begin
            if (mem_block) begin
                mem_wb_valid_d = 1'b0;
            end else begin
                mem_wb_valid_d  = live;
                mem_wb_type_d   = ex_mem_type;
                mem_wb_ir_d     = ex_mem_ir;
                mem_wb_aluout_d = ex_mem_aluout;
                if (live && ex_mem_type == T_LOAD) begin
                    if (in_range) begin
                        mem_wb_lmd_d = dmem[dmem_addr];
                    end else begin
                        mem_wb_lmd_d = '0;
                        mem_err_d    = 1'b1;
                    end
                end
                if (live && ex_mem_type == T_STORE) begin
                    if (in_range) begin
                        // rst_n gate: an edge seen while reset is asserted must not land a store
                        dmem_we = rst_n;
                    end else begin
                        mem_err_d = 1'b1;
                    end
                end
            end
        end
    end

    // WB stage: destination/data select, halt detection, register-file update
    always_comb begin
        logic [4:0]  cand_dest;
        logic [31:0] cand_data;
        logic        has_dest;
        cand_dest = '0;
        cand_data = '0;
        has_dest  = 1'b0;
        halted_d  = halted_q;
        if (mem_wb_valid_q && !halted_q) begin
            case (mem_wb_type_q)
                T_RR_ALU: begin
                    cand_dest = mem_wb_ir_q[15:11];
                    cand_data = mem_wb_aluout_q;
                    has_dest  = 1'b1;
                end
                T_RM_ALU: begin
                    cand_dest = mem_wb_ir_q[20:16];
                    cand_data = mem_wb_aluout_q;
                    has_dest  = 1'b1;
                end
                T_LOAD: begin
                    cand_dest = mem_wb_ir_q[20:16];
                    cand_data = mem_wb_lmd_q;
                    has_dest  = 1'b1;
                end
                T_HALT:  halted_d = 1'b1;
                default: has_dest = 1'b0;
            endcase
        end
        wr_en   = has_dest && (cand_dest != 5'd0);
        wr_dest = wr_en ? cand_dest : 5'd0;
        wr_data = wr_en ? cand_data : 32'd0;

        if (halted_q) begin
            wb_we_d   = wb_we_q;
            wb_addr_d = wb_addr_q;
            wb_data_d = wb_data_q;
        end else begin
            wb_we_d   = wr_en;
            wb_addr_d = wr_dest;
            wb_data_d = wr_data;
        end

        for (int unsigned i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_dest] = wr_data;
        end
    end

    // Read ports: r0 is hard zero; a write landing this cycle is forwarded
    always_comb begin
        if (rd_addr_a == 5'd0)                     rd_data_a = '0;
        else if (wr_en && wr_dest == rd_addr_a)    rd_data_a = wr_data;
        else                                       rd_data_a = regs_q[rd_addr_a];
        if (rd_addr_b == 5'd0)                     rd_data_b = '0;
        else if (wr_en && wr_dest == rd_addr_b)    rd_data_b = wr_data;
        else                                       rd_data_b = regs_q[rd_addr_b];
    end

    // Pipeline register and status flops
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_valid_q  <= 1'b0;
            mem_wb_type_q   <= '0;
            mem_wb_ir_q     <= '0;
            mem_wb_aluout_q <= '0;
            mem_wb_lmd_q    <= '0;
            wb_we_q         <= 1'b0;
            wb_addr_q       <= '0;
            wb_data_q       <= '0;
            halted_q        <= 1'b0;
            mem_err_q       <= 1'b0;
        end else begin
            mem_wb_valid_q  <= mem_wb_valid_d;
            mem_wb_type_q   <= mem_wb_type_d;
            mem_wb_ir_q     <= mem_wb_ir_d;
            mem_wb_aluout_q <= mem_wb_aluout_d;
            mem_wb_lmd_q    <= mem_wb_lmd_d;
            wb_we_q         <= wb_we_d;
            wb_addr_q       <= wb_addr_d;
            wb_data_q       <= wb_data_d;
            halted_q        <= halted_d;
            mem_err_q       <= mem_err_d;
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge clk1) begin
        if (dmem_we) begin
            dmem[dmem_addr] <= ex_mem_b;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign halted  = halted_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_riscv_mem_wb.sv
// Testbench for riscv_mem_wb: directed vectors, write-back scoreboard.
module tb_riscv_mem_wb;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } itype_e;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    logic        clk1;
    logic        rst_n;
    logic        ex_mem_valid;
    logic [2:0]  ex_mem_type;
    logic [31:0] ex_mem_ir;
    logic [31:0] ex_mem_aluout;
    logic [31:0] ex_mem_b;
    logic        taken_branch;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;
    logic        mem_err;

    int  n_checks = 0;
    int  n_fail   = 0;
    wb_t exp_q[$];

    riscv_mem_wb #(
        .DMEM_DEPTH(1024),
        .DMEM_AW   (10)
    ) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .ex_mem_valid (ex_mem_valid),
        .ex_mem_type  (ex_mem_type),
        .ex_mem_ir    (ex_mem_ir),
        .ex_mem_aluout(ex_mem_aluout),
        .ex_mem_b     (ex_mem_b),
        .taken_branch (taken_branch),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .halted       (halted),
        .mem_err      (mem_err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Monitor: every write-back strobe must match the oldest expected write
    always @(negedge clk1) begin
        wb_t e;
        if (rst_n && wb_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_addr !== e.a || wb_data !== e.d) begin
                    n_fail++;
                    $display("FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             wb_addr, wb_data, e.a, e.d);
                end
            end
        end
    end

    function automatic logic [31:0] ir_rt(input int unsigned rt);
        logic [31:0] v;
        v = 32'(rt) << 16;
        return v;
    endfunction

    function automatic logic [31:0] ir_rd(input int unsigned rd);
        logic [31:0] v;
        v = 32'(rd) << 11;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        rd_addr_b = r;
        #1;
        check(name, rd_data_b, exp);
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
        wb_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Present one EX/MEM slot, hold it across the next rising edge
    task automatic drive(input itype_e t, input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] b, input logic sq);
        ex_mem_valid  = 1'b1;
        ex_mem_type   = t;
        ex_mem_ir     = ir;
        ex_mem_aluout = alu;
        ex_mem_b      = b;
        taken_branch  = sq;
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ex_mem_valid = 1'b0;
            taken_branch = 1'b0;
            @(posedge clk1);
            #1;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        ex_mem_valid  = 1'b0;
        ex_mem_type   = '0;
        ex_mem_ir     = '0;
        ex_mem_aluout = '0;
        ex_mem_b      = '0;
        taken_branch  = 1'b0;
        rd_addr_a     = '0;
        rd_addr_b     = '0;

        // Reset state
        repeat (2) @(posedge clk1);
        #1;
        check("reset_wb_we", 32'(wb_we), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_mem_err", 32'(mem_err), 32'd0);
        check_reg("reset_r5", 5'd5, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // ADDI r5 = 0xA, bypass while in MEM/WB, then from the file
        expect_wb(5'd5, 32'h0000_000A);
        drive(RM_ALU, ir_rt(5), 32'h0000_000A, 32'd0, 1'b0);
        rd_addr_a = 5'd5;
        #1;
        check("addi_bypass_a", rd_data_a, 32'h0000_000A);
        idle(2);
        check("addi_rf_a", rd_data_a, 32'h0000_000A);

        // Store 0x14 then load it into r7 on the following cycle
        drive(STORE, ir_rt(3), 32'h0000_0014, 32'hDEAD_BEEF, 1'b0);
        expect_wb(5'd7, 32'hDEAD_BEEF);
        drive(LOAD, ir_rt(7), 32'h0000_0014, 32'd0, 1'b0);
        idle(2);
        check_reg("st_ld_r7", 5'd7, 32'hDEAD_BEEF);
        check("st_ld_mem_err", 32'(mem_err), 32'd0);

        // Squashed store must not overwrite; squashed ALU op must not write
        drive(STORE, 32'd0, 32'h0000_0020, 32'h0000_1234, 1'b0);
        drive(STORE, 32'd0, 32'h0000_0020, 32'h0000_0055, 1'b1);
        drive(RR_ALU, ir_rd(12), 32'h0000_0099, 32'd0, 1'b1);
        expect_wb(5'd11, 32'h0000_1234);
        drive(LOAD, ir_rt(11), 32'h0000_0020, 32'd0, 1'b0);
        idle(2);
        check_reg("squash_store_r11", 5'd11, 32'h0000_1234);
        check_reg("squash_alu_r12", 5'd12, 32'd0);

        // Write to r0 is suppressed; r0 reads zero
        drive(RM_ALU, ir_rt(0), 32'h0000_0077, 32'd0, 1'b0);
        rd_addr_a = 5'd0;
        idle(2);
        #1;
        check("r0_read", rd_data_a, 32'd0);

        // Out-of-range load zeroes its destination and latches mem_err
        expect_wb(5'd10, 32'h0000_0005);
        drive(RM_ALU, ir_rt(10), 32'h0000_0005, 32'd0, 1'b0);
        expect_wb(5'd10, 32'd0);
        drive(LOAD, ir_rt(10), 32'h0000_0400, 32'd0, 1'b0);
        idle(2);
        check_reg("oor_load_r10", 5'd10, 32'd0);
        check("oor_mem_err", 32'(mem_err), 32'd1);

        // Out-of-range store must not alias into the low address
        drive(STORE, 32'd0, 32'h0000_0030, 32'h0000_CAFE, 1'b0);
        drive(STORE, 32'd0, 32'h8000_0030, 32'h0000_0BAD, 1'b0);
        drive(STORE, 32'd0, 32'h0000_03FF, 32'h003F_F3FF, 1'b0);
        expect_wb(5'd13, 32'h0000_CAFE);
        drive(LOAD, ir_rt(13), 32'h0000_0030, 32'd0, 1'b0);
        expect_wb(5'd15, 32'h003F_F3FF);
        drive(LOAD, ir_rt(15), 32'h0000_03FF, 32'd0, 1'b0);
        idle(2);
        check_reg("oor_noalias_r13", 5'd13, 32'h0000_CAFE);
        check_reg("top_word_r15", 5'd15, 32'h003F_F3FF);
        check("mem_err_sticky", 32'(mem_err), 32'd1);

        // Halt ordering: ADD r3, HALT, STORE (blocked)
        drive(STORE, 32'd0, 32'h0000_0008, 32'h0000_0077, 1'b0);
        expect_wb(5'd3, 32'h0000_0011);
        drive(RR_ALU, ir_rt(4) | ir_rd(3), 32'h0000_0011, 32'd0, 1'b0);
        drive(HALT, 32'd0, 32'd0, 32'd0, 1'b0);
        check("halt_not_yet", 32'(halted), 32'd0);
        drive(STORE, 32'd0, 32'h0000_0008, 32'h0000_0099, 1'b0);
        check("halted_set", 32'(halted), 32'd1);
        drive(RM_ALU, ir_rt(6), 32'h0000_0066, 32'd0, 1'b0);
        drive(STORE, 32'd0, 32'h0000_0008, 32'h0000_0099, 1'b0);
        idle(2);
        check_reg("halt_r3", 5'd3, 32'h0000_0011);
        check_reg("halt_frozen_r6", 5'd6, 32'd0);
        check("halted_sticky", 32'(halted), 32'd1);

        // Reset clears halt; dmem survives and the blocked stores never landed
        rst_n = 1'b0;
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check_reg("rst_r3", 5'd3, 32'd0);
        rst_n = 1'b1;
        idle(1);
        expect_wb(5'd16, 32'h0000_0077);
        drive(LOAD, ir_rt(16), 32'h0000_0008, 32'd0, 1'b0);
        idle(2);
        check_reg("halt_store_blocked_r16", 5'd16, 32'h0000_0077);
        check("rst_mem_err", 32'(mem_err), 32'd0);

        // Reset while a LOAD to r9 sits in MEM/WB
        expect_wb(5'd9, 32'h0000_0099);
        drive(RM_ALU, ir_rt(9), 32'h0000_0099, 32'd0, 1'b0);
        drive(LOAD, ir_rt(9), 32'h0000_0014, 32'd0, 1'b0);
        ex_mem_valid = 1'b0;
        @(negedge clk1);
        #1;
        check("preflight_wb_we", 32'(wb_we), 32'd1);
        check_reg("preflight_r9_bypass", 5'd9, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        check("midrst_wb_we", 32'(wb_we), 32'd0);
        check_reg("midrst_r9", 5'd9, 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
        idle(3);
        check_reg("midrst_r9_after", 5'd9, 32'd0);

        // Squashed HALT never halts
        drive(HALT, 32'd0, 32'd0, 32'd0, 1'b1);
        idle(3);
        check("squashed_halt", 32'(halted), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
